// File: rtl/float_minmax_reducer_pkg.sv
// Shared FP32 helpers for the min/max reduction engine.
//   FP32_CANONICAL_NAN : quiet NaN produced when both compare operands are NaN
//   isNaN / isSNaN     : FP32 NaN classification helpers
//   state_e            : reduction FSM states
package float_minmax_reducer_pkg;

    localparam logic [31:0] FP32_CANONICAL_NAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic isNaN(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // A signaling NaN has a non-zero fraction with the quiet bit clear.
    function automatic logic isSNaN(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0) && !x[22];
    endfunction

endpackage

// File: rtl/float_minmax_reducer_if.sv
// Handshake bundle for float_minmax_reducer.
//   start_* : reduction request (seed, count, max/min select)
//   in_*    : element stream, one FP32 beat plus active mask
//   out_*   : reduced result and signaling-NaN flag
// modport slave is the reducer side, modport master is the requester side.
interface float_minmax_reducer_if #(
    parameter int COUNT_W = 12
);
    logic               start_valid;
    logic               start_ready;
    logic               start_bits_isMax;
    logic [31:0]        start_bits_seed;
    logic [COUNT_W-1:0] start_bits_count;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_bits_data;
    logic               in_bits_mask;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_bits_result;
    logic               out_bits_invalid;

    modport slave (
        input  start_valid, start_bits_isMax, start_bits_seed, start_bits_count,
        output start_ready,
        input  in_valid, in_bits_data, in_bits_mask,
        output in_ready,
        output out_valid, out_bits_result, out_bits_invalid,
        input  out_ready
    );

    modport master (
        output start_valid, start_bits_isMax, start_bits_seed, start_bits_count,
        input  start_ready,
        output in_valid, in_bits_data, in_bits_mask,
        input  in_ready,
        input  out_valid, out_bits_result, out_bits_invalid,
        output out_ready
    );
endinterface

// File: rtl/float_minmax_reducer_float_compare.sv
// FloatCompare: combinational FP32 max/min of two operands.
//   a, b   : FP32 operands
//   isMax  : 1 selects the larger operand, 0 the smaller
//   result : selected operand; a lone NaN yields the other operand,
//            two NaNs yield the canonical quiet NaN
module FloatCompare
    import float_minmax_reducer_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        isMax,
    output logic [31:0] result
);
    logic        a_nan;
    logic        b_nan;
    logic [31:0] key_a;
    logic [31:0] key_b;

    // Map sign-magnitude to an unsigned key whose ordering matches the
    // numeric ordering; -0 lands just below +0, giving the required
    // max(+0,-0)=+0 and min(+0,-0)=-0 without a special case.
    assign key_a = a[31] ? ~a : (a | 32'h8000_0000);
    assign key_b = b[31] ? ~b : (b | 32'h8000_0000);
    assign a_nan = isNaN(a);
    assign b_nan = isNaN(b);

    always_comb begin
        result = a;
        if (a_nan && b_nan) begin
            result = FP32_CANONICAL_NAN;
        end else if (a_nan) begin
            result = b;
        end else if (b_nan) begin
            result = a;
        end else if (isMax) begin
            result = (key_b > key_a) ? b : a;
        end else begin
            result = (key_b < key_a) ? b : a;
        end
    end
endmodule

// File: rtl/float_minmax_reducer.sv
// float_minmax_reducer: sequential FP32 min/max reduction.
//   clock, reset : single clock, synchronous active-low reset
//   bus (slave)  : start request (seed/count/isMax), element stream
//                  (data/mask), result (value + signaling-NaN flag)
// A seed is latched in IDLE, count beats are folded in ACCUM (one per cycle,
// masked-off beats consumed but ignored) and the result is offered in DONE.
module float_minmax_reducer
    import float_minmax_reducer_pkg::*;
#(
    parameter int COUNT_W = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    float_minmax_reducer_if.slave bus
);
    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic               is_max_q, is_max_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               invalid_q, invalid_d;
    logic [31:0]        cmp_result;

    FloatCompare u_cmp (
        .a      (acc_q),
        .b      (bus.in_bits_data),
        .isMax  (is_max_q),
        .result (cmp_result)
    );

    // Outputs depend only on state and registers.
    assign bus.start_ready      = (state_q == IDLE);
    assign bus.in_ready         = (state_q == ACCUM);
    assign bus.out_valid        = (state_q == DONE);
    assign bus.out_bits_result  = (state_q == DONE) ? acc_q : 32'd0;
    assign bus.out_bits_invalid = (state_q == DONE) && invalid_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        is_max_d    = is_max_q;
        remaining_d = remaining_q;
        invalid_d   = invalid_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    acc_d       = bus.start_bits_seed;
                    is_max_d    = bus.start_bits_isMax;
                    remaining_d = bus.start_bits_count;
                    invalid_d   = isSNaN(bus.start_bits_seed);
                    state_d     = (bus.start_bits_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    if (bus.in_bits_mask) begin
                        acc_d     = cmp_result;
                        invalid_d = invalid_q | isSNaN(bus.in_bits_data);
                    end
                    // remaining is always >= 1 here, so this never wraps.
                    remaining_d = remaining_q - COUNT_W'(1);
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            is_max_q    <= 1'b0;
            remaining_q <= '0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            is_max_q    <= is_max_d;
            remaining_q <= remaining_d;
            invalid_q   <= invalid_d;
        end
    end
endmodule

// File: tb/tb_float_minmax_reducer.sv
// Directed bench for float_minmax_reducer. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_float_minmax_reducer;
    import float_minmax_reducer_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   lat;
    logic [31:0] elems [8];
    logic        masks [8];

    float_minmax_reducer_if #(.COUNT_W(12)) bus ();

    float_minmax_reducer #(.COUNT_W(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic m, input logic [31:0] seed, input logic [11:0] cnt);
        bus.start_valid      = 1'b1;
        bus.start_bits_isMax = m;
        bus.start_bits_seed  = seed;
        bus.start_bits_count = cnt;
        tick();
        bus.start_valid = 1'b0;
        lat = 1;
    endtask

    // Feed n beats from elems/masks; gaps[i] inserts a bubble before beat i.
    task automatic feed(input int n, input logic [7:0] gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps[i]) begin
                bus.in_valid = 1'b0;
                tick();
                lat++;
            end
            bus.in_valid     = 1'b1;
            bus.in_bits_data = elems[i];
            bus.in_bits_mask = masks[i];
            tick();
            lat++;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
            lat++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic single(input string tag, input logic m, input logic [31:0] seed,
                          input logic [31:0] d, input logic mk,
                          input logic [31:0] exp_res, input logic exp_inv);
        start_job(m, seed, 12'd1);
        elems[0] = d;
        masks[0] = mk;
        feed(1, 8'h00);
        wait_out();
        check_eq({tag, "_res"}, bus.out_bits_result, exp_res);
        check_eq({tag, "_inv"}, 32'(bus.out_bits_invalid), 32'(exp_inv));
        take_out();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        lat = 0;
        reset = 1'b0;
        bus.start_valid = 1'b0;
        bus.start_bits_isMax = 1'b0;
        bus.start_bits_seed = 32'd0;
        bus.start_bits_count = 12'd0;
        bus.in_valid = 1'b0;
        bus.in_bits_data = 32'd0;
        bus.in_bits_mask = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", bus.out_bits_result, 32'd0);
        check_eq("rst_invalid", 32'(bus.out_bits_invalid), 32'd0);
        reset = 1'b1;
        tick();

        // Max reduction at full rate: latency count+1.
        start_job(1'b1, 32'hFF800000, 12'd3);
        check_eq("max_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("max_start_ready", 32'(bus.start_ready), 32'd0);
        elems[0] = 32'h3F800000; masks[0] = 1'b1;
        elems[1] = 32'hC0000000; masks[1] = 1'b1;
        elems[2] = 32'h40600000; masks[2] = 1'b1;
        feed(2, 8'h00);
        check_eq("max_not_early", 32'(bus.out_valid), 32'd0);
        elems[0] = elems[2];
        feed(1, 8'h00);
        check_eq("max_valid", 32'(bus.out_valid), 32'd1);
        check_eq("max_latency", 32'(lat), 32'd4);
        check_eq("max_res", bus.out_bits_result, 32'h40600000);
        check_eq("max_inv", 32'(bus.out_bits_invalid), 32'd0);
        take_out();
        check_eq("max_back_idle", 32'(bus.start_ready), 32'd1);
        check_eq("max_out_drop", 32'(bus.out_valid), 32'd0);

        // Signed zeros.
        single("zmin", 1'b0, 32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0);
        single("zmax", 1'b1, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0);

        // NaN rules.
        single("qnan_one", 1'b1, 32'h7FC00000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0);
        single("nan_two", 1'b1, 32'h7FC00000, 32'h7F800001, 1'b1, 32'h7FC00000, 1'b1);
        single("snan_seed", 1'b0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h3F800000, 1'b1);
        single("snan_masked", 1'b1, 32'h3F800000, 32'h7FA00000, 1'b0, 32'h3F800000, 1'b0);

        // Masked-off beat is consumed but ignored.
        start_job(1'b0, 32'h00000000, 12'd2);
        elems[0] = 32'h40A00000; masks[0] = 1'b0;
        elems[1] = 32'hBF800000; masks[1] = 1'b1;
        feed(2, 8'h00);
        wait_out();
        check_eq("mask_res", bus.out_bits_result, 32'hBF800000);
        take_out();

        // Zero count goes straight to DONE.
        start_job(1'b1, 32'h12345678, 12'd0);
        check_eq("cnt0_valid", 32'(bus.out_valid), 32'd1);
        check_eq("cnt0_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("cnt0_res", bus.out_bits_result, 32'h12345678);
        take_out();

        // Bubbles and output backpressure, with a competing start held high.
        start_job(1'b1, 32'hFF800000, 12'd4);
        elems[0] = 32'h3F800000; masks[0] = 1'b1;
        elems[1] = 32'h40A00000; masks[1] = 1'b1;
        elems[2] = 32'hC0000000; masks[2] = 1'b1;
        elems[3] = 32'h40600000; masks[3] = 1'b1;
        feed(4, 8'h0B);
        check_eq("bp_latency", 32'(lat), 32'd8);
        check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.start_valid = 1'b1;
        bus.start_bits_seed = 32'h00000000;
        bus.start_bits_count = 12'd0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_res", bus.out_bits_result, 32'h40A00000);
            check_eq("bp_start_ready", 32'(bus.start_ready), 32'd0);
            tick();
        end
        bus.start_valid = 1'b0;
        check_eq("bp_release_res", bus.out_bits_result, 32'h40A00000);
        take_out();
        check_eq("bp_idle", 32'(bus.start_ready), 32'd1);

        // Reset in the middle of a job.
        start_job(1'b1, 32'h00000000, 12'd4);
        elems[0] = 32'h3F800000; masks[0] = 1'b1;
        elems[1] = 32'h40000000; masks[1] = 1'b1;
        feed(2, 8'h00);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("mid_rst_result", bus.out_bits_result, 32'd0);
        single("after_rst", 1'b0, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/float_minmax_reducer.md
# float_minmax_reducer

Sequential FP32 min/max reduction engine for the vector floating-point unit. It executes `vfredmax`/`vfredmin`-style reductions: it accepts a scalar seed, then folds a stream of masked FP32 elements into an accumulator, one element per cycle. The fold uses a single shared `FloatCompare` instance. It sits between the lane element sequencer and the reduction writeback path.

## Interface
Parameters:
- `COUNT_W`, default 12: width of the element-count field.

Ports:
- `clock`  in  1: the block's single clock.
- `reset`  in  1: synchronous, active-low reset. It takes effect when sampled 0 on a rising `clock` edge.
- `start_valid`  in  1: a reduction request is present.
- `start_ready`  out  1: the block can accept a request. High only in IDLE.
- `start_bits_isMax`  in  1: 1 selects max, 0 selects min.
- `start_bits_seed`  in  32: initial accumulator value (FP32 bits).
- `start_bits_count`  in  COUNT_W: number of element beats to consume. 0 is legal.
- `in_valid`  in  1: an element beat is present.
- `in_ready`  out  1: the block accepts an element this cycle.
- `in_bits_data`  in  32: FP32 element.
- `in_bits_mask`  in  1: 1 means the element is active; 0 means the beat is consumed and ignored.
- `out_valid`  out  1: the result is available.
- `out_ready`  in  1: the consumer takes the result.
- `out_bits_result`  out  32: reduced FP32 value.
- `out_bits_invalid`  out  1: set if the seed or any active element was a signaling NaN.

## Operation
- The state machine has three states: IDLE, ACCUM and DONE. Reset forces IDLE.
- **IDLE, on start handshake:**
  - `acc <= seed`, `isMax <= start_bits_isMax`, `remaining <= count`.
  - `invalid <= isSNaN(seed)`.
  - Next state is DONE if `count == 0`, otherwise ACCUM.
- **ACCUM:**
  - `in_ready = 1`.
  - On an `in` handshake with `mask=1`: `acc <= FloatCompare(a=acc, b=in_bits_data, isMax)`, and `invalid |= isSNaN(data)`.
  - On an `in` handshake with `mask=0`: `acc` is unchanged.
  - Every handshake decrements `remaining`. When the handshake with `remaining == 1` occurs, the next state is DONE.
- **DONE:**
  - `out_valid = 1`, `out_bits_result = acc`, `out_bits_invalid = invalid`.
  - On `out_ready`, the next state is IDLE.
- `isSNaN(x)` is defined as `x[30:23] == 8'hFF && x[22:0] != 0 && x[22] == 0`.
- NaN and zero semantics are exactly those of `FloatCompare`:
  - One NaN operand returns the other operand.
  - Two NaN operands return `32'h7FC00000`.
  - For zeros of opposite sign, max returns +0 and min returns −0.
- Outputs are driven purely from state and registers. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `start_ready`.
- `in_ready` is 0 outside ACCUM; beats presented then are not consumed.
- A `start_valid` presented outside IDLE is not accepted and is held off by `start_ready = 0`.

## Timing
- Throughput: one element per cycle in ACCUM.
- Latency: `out_valid` rises on the cycle after the last element handshake, or on the cycle after the start handshake when `count == 0`.
- Total cycles from the start handshake to `out_valid` equal `count + 1` at full input rate.
- Bubbles (`in_valid = 0`) stall ACCUM with no state change.
- The result is held stable while `out_valid && !out_ready`.
- A new start is accepted no earlier than the cycle after the out handshake, so there is at least one IDLE cycle between jobs.
- Reset values:
  - `start_ready = 1` (IDLE), `in_ready = 0`, `out_valid = 0`.
  - `out_bits_result = 0`, `out_bits_invalid = 0`.
  - `acc = 0`, `remaining = 0`, `invalid = 0`.
- Reset asserted mid-ACCUM or mid-DONE abandons the job. The next cycle is IDLE with reset values, and no result is emitted.
- `remaining` is an unsigned COUNT_W-bit counter and never wraps: it is only decremented in ACCUM, where it is ≥ 1.

## Structure
- A shared FP package holds:
  - the `FP32_CANONICAL_NAN = 32'h7FC00000` constant;
  - the `isSNaN`/`isNaN` helper functions;
  - the state enum `{IDLE, ACCUM, DONE}` (2 bits).
- There is one sub-module, `FloatCompare`, instantiated once. Its `a` input is wired to `acc`, `b` to `in_bits_data`, and `isMax` to the registered `isMax`. Its output feeds the `acc` next-value mux.
- Everything else is local: the FSM, the `remaining` counter, and the `acc`/`invalid`/`isMax` registers.

## Test plan
- **Max reduction.** isMax=1, seed=`FF800000`, count=3, elements `3F800000`, `C0000000`, `40600000`, all masked on. Expect result `40600000`, invalid=0, `out_valid` 4 cycles after start.
- **Signed zero with min.** isMax=0, seed=`00000000`, count=1, element `80000000`. Expect `80000000`. Repeat with isMax=1 and expect `00000000`.
- **NaN rules.**
  - Seed `7FC00000`, element `3F800000`: expect `3F800000`, invalid=0.
  - Seed `7FC00000`, element `7F800001`: expect `7FC00000`, invalid=1.
- **Mask and zero count.**
  - Count=2, elements `40A00000` (mask=0) and `BF800000` (mask=1), seed `00000000`, min: expect `BF800000`.
  - Count=0, seed `12345678`: expect `12345678` one cycle after start, with `in_ready` never asserted.
- **Backpressure and bubbles.** Count=4, random `in_valid` gaps, `out_ready` held low for 5 cycles. Expect the result stable, `start_ready = 0` throughout, and the correct value on release.
- **Reset mid-job.** Assert `reset = 0` after 2 of 4 beats. Expect IDLE next cycle, `out_valid = 0`, and that a fresh job with count=1 completes correctly.
